// File: rtl/pattern_detector_prog.sv
// pattern_detector_prog: runtime-programmable serial bit-pattern detector with
// overlap control, valid-qualified input and a saturating match counter.
module pattern_detector_prog #(
    parameter  int MAX_LEN = 16,
    parameter  int CNT_W   = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               cfg_overlap_i,
    output logic               cfg_err_o,
    input  logic               in_valid_i,
    input  logic               in_bit_i,
    input  logic               cnt_clr_i,
    output logic               armed_o,
    output logic               match_o,
    output logic [CNT_W-1:0]   match_count_o
);
    typedef enum logic [1:0] {IDLE, FILL, HUNT} state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d, hist_sh, mask;
    logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d;
    logic [LEN_W:0]     fill_nx;
    logic               ovl_q, ovl_d, match_q, match_d, err_q, err_d;
    logic               cfg_ok, full, hit;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign cfg_ok  = cfg_len_i != '0 && int'(cfg_len_i) <= MAX_LEN;
    assign hist_sh = {hist_q[MAX_LEN-2:0], in_bit_i};
    assign fill_nx = {1'b0, fill_q} + (LEN_W+1)'(1);
    assign full    = fill_nx >= {1'b0, len_q};
    // Only the low len bits of history and pattern take part in the compare.
    assign mask    = {MAX_LEN{1'b1}} >> (MAX_LEN - int'(len_q));
    assign hit     = full && ((hist_sh ^ pat_q) & mask) == '0;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        err_d   = 1'b0;
        if (cfg_load_i && cfg_ok) begin
            pat_d   = cfg_pattern_i;
            len_d   = cfg_len_i;
            ovl_d   = cfg_overlap_i;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else begin
            err_d = cfg_load_i;
            if (state_q != IDLE && in_valid_i) begin
                hist_d  = hist_sh;
                match_d = hit;
                if (hit && !ovl_q) begin
                    fill_d  = '0;
                    state_d = FILL;
                end else begin
                    fill_d  = full ? len_q : fill_nx[LEN_W-1:0];
                    state_d = full ? HUNT : FILL;
                end
            end
        end
        cnt_d = cnt_clr_i ? CNT_W'(match_d)
              : (match_d && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cfg_err_o     = err_q;
    assign armed_o       = state_q != IDLE;
    assign match_o       = match_q;
    assign match_count_o = cnt_q;
endmodule

// File: tb/tb_pattern_detector_prog.sv
// tb_pattern_detector_prog: directed and random stimulus against a queue-based
// reference model; a second instance with CNT_W=2 exercises counter saturation.
module tb_pattern_detector_prog;
    localparam int ML = 16;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          reset, cfg_load_i, cfg_overlap_i, in_valid_i, in_bit_i, cnt_clr_i;
    logic [ML-1:0] cfg_pattern_i;
    logic [LW-1:0] cfg_len_i;
    logic          cfg_err_o, armed_o, match_o, cfg_err2, armed2, match2;
    logic [15:0]   cnt_o;
    logic [1:0]    cnt2;

    always #5 clk = ~clk;

    pattern_detector_prog #(.MAX_LEN(ML), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .cfg_load_i(cfg_load_i), .cfg_pattern_i(cfg_pattern_i),
        .cfg_len_i(cfg_len_i), .cfg_overlap_i(cfg_overlap_i), .cfg_err_o(cfg_err_o),
        .in_valid_i(in_valid_i), .in_bit_i(in_bit_i), .cnt_clr_i(cnt_clr_i),
        .armed_o(armed_o), .match_o(match_o), .match_count_o(cnt_o)
    );

    pattern_detector_prog #(.MAX_LEN(ML), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .cfg_load_i(cfg_load_i), .cfg_pattern_i(cfg_pattern_i),
        .cfg_len_i(cfg_len_i), .cfg_overlap_i(cfg_overlap_i), .cfg_err_o(cfg_err2),
        .in_valid_i(in_valid_i), .in_bit_i(in_bit_i), .cnt_clr_i(cnt_clr_i),
        .armed_o(armed2), .match_o(match2), .match_count_o(cnt2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    bit          m_armed, m_ovl, m_match, m_err;
    logic [15:0] m_pat;
    int          m_len, m_cnt, m_cnt2;
    bit          q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit rst, input bit ld, input logic [15:0] pat, input int len,
                        input bit ovl, input bit v, input bit b, input bit clr);
        reset         = rst;
        cfg_load_i    = ld;
        cfg_pattern_i = pat;
        cfg_len_i     = LW'(len);
        cfg_overlap_i = ovl;
        in_valid_i    = v;
        in_bit_i      = b;
        cnt_clr_i     = clr;
        @(posedge clk);
        if (rst) begin
            m_armed = 0; m_pat = '0; m_len = 0; m_ovl = 0; q.delete();
            m_match = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            m_match = 0;
            m_err   = 0;
            if (ld && len >= 1 && len <= ML) begin
                m_armed = 1; m_pat = pat; m_len = len; m_ovl = ovl; q.delete();
            end else begin
                m_err = ld;
                if (m_armed && v) begin
                    q.push_back(b);
                    if (q.size() > m_len) void'(q.pop_front());
                    if (q.size() == m_len) begin
                        m_match = 1;
                        for (int i = 0; i < m_len; i++)
                            if (q[i] != m_pat[m_len-1-i]) m_match = 0;
                    end
                    if (m_match && !m_ovl) q.delete();
                end
            end
            m_cnt  = clr ? int'(m_match) : (m_cnt + int'(m_match) > 65535 ? 65535 : m_cnt + int'(m_match));
            m_cnt2 = clr ? int'(m_match) : (m_cnt2 + int'(m_match) > 3 ? 3 : m_cnt2 + int'(m_match));
        end
        #1;
        check("match", match_o, m_match);
        check("match_w2", match2, m_match);
        check("cfg_err", cfg_err_o, m_err);
        check("armed", armed_o, m_armed);
        check("count", cnt_o, m_cnt);
        check("count_w2", cnt2, m_cnt2);
    endtask

    task automatic bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(0, 0, 0, 0, 0, 1, v[i], 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input logic [15:0] pat, input int len, input bit ovl);
        step(0, 1, pat, len, ovl, 0, 0, 0);
    endtask

    int r, l;

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0);
        check("reset_count", cnt_o, 0);
        idle(1);
        // overlapping 1101 over 1101101
        load(16'hD, 4, 1);
        bits(16'b1101101, 7);
        check("t1_count", cnt_o, 2);
        // non-overlapping
        step(0, 0, 0, 0, 0, 0, 0, 1);
        load(16'hD, 4, 0);
        bits(16'b1101101, 7);
        check("t2_count", cnt_o, 1);
        bits(16'b1101, 4);
        check("t2_count2", cnt_o, 2);
        // illegal lengths from reset
        step(1, 0, 0, 0, 0, 0, 0, 0);
        load(16'hD, 0, 1);
        check("t3_err0", cfg_err_o, 1);
        load(16'hD, ML + 1, 1);
        check("t3_err17", cfg_err_o, 1);
        bits(16'b1101, 4);
        check("t3_armed", armed_o, 0);
        // gaps in in_valid
        load(16'hD, 4, 1);
        bits(16'b1, 1);
        idle(3);
        bits(16'b101, 3);
        check("t4_match", match_o, 1);
        idle(1);
        check("t4_single", match_o, 0);
        // illegal load mid-stream leaves the stream intact
        bits(16'b110, 3);
        step(0, 1, 16'h0, ML + 1, 0, 1, 1, 0);
        check("t4_mid_err_match", match_o, 1);
        // saturation on the 2-bit counter
        step(0, 0, 0, 0, 0, 0, 0, 1);
        load(16'h1, 1, 0);
        bits(16'b111111, 6);
        check("t5_sat", cnt2, 3);
        step(0, 0, 0, 0, 0, 1, 1, 1);
        check("t5_clr_hit", cnt2, 1);
        bits(16'b0, 1);
        // reset mid-pattern, then reload and send the last bit
        load(16'hD, 4, 1);
        bits(16'b110, 3);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        load(16'hD, 4, 1);
        bits(16'b1, 1);
        check("t6_no_match_rst", match_o, 0);
        // reload mid-pattern discards partial history; same-cycle bit is dropped
        bits(16'b110, 3);
        step(0, 1, 16'hD, 4, 1, 1, 1, 0);
        bits(16'b1, 1);
        check("t6_no_match_load", match_o, 0);
        // full-length pattern
        load(16'hA5C3, 16, 1);
        bits(16'hA5C3, 16);
        check("t7_len16", match_o, 1);
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(99);
            if (r == 0) step(1, 0, 0, 0, 0, 0, 0, 0);
            else if (r < 4) begin
                l = ($urandom_range(3) == 0) ? $urandom_range(17) : $urandom_range(4, 1);
                step(0, 1, 16'($urandom), l, 1'($urandom), 1'($urandom), 1'($urandom), 0);
            end else
                step(0, 0, 0, 0, 0, $urandom_range(3) != 0, 1'($urandom), $urandom_range(49) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
